pipe_hazard_ctrl: RTL and testbench

- Central stall/flush/forwarding controller for the 5-stage miniRV pipeline (IF/ID/EX/MEM/WB).
- Detects RAW hazards between the ID source registers and the EX/MEM/WB destinations. Generates forwarding selects, the load-use bubble and the branch/jump redirect flush.
- Sequences the multi-cycle mul/div unit through a small FSM with a watchdog.
- Sits beside the pipeline registers and drives their stall/flush enables.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 39 +++
 rtl/pipe_hazard_ctrl_if.sv | 51 +++++
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the miniRV hazard controller: forwarding selects,
// mul/div FSM state codes and the packed stall/flush control bundle.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_SEL_RF  = 2'd0;
    localparam logic [1:0] FWD_SEL_EX  = 2'd1;
    localparam logic [1:0] FWD_SEL_MEM = 2'd2;
    localparam logic [1:0] FWD_SEL_WB  = 2'd3;

    typedef enum logic {
        MD_FSM_RUN  = 1'b0,
        MD_FSM_WAIT = 1'b1
    } md_state_e;

    // Wide enough for the largest legal MD_MAX_CYC (255).
    localparam int MD_CNT_W = 8;

    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic flush_if_id;
        logic flush_id_ex;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t PIPE_CTRL_IDLE = '0;

    function automatic pipe_ctrl_t freezeAll();
        pipe_ctrl_t c;
        c              = PIPE_CTRL_IDLE;
        c.stall_pc     = 1'b1;
        c.stall_if_id  = 1'b1;
        c.stall_id_ex  = 1'b1;
        c.stall_ex_mem = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline side uses
// the master modport, the controller uses the slave modport.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5
);

    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_re;
    logic              id_rs2_re;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic              ex_wen;
    logic              mem_wen;
    logic              wb_wen;
    logic              ex_is_load;
    logic              ex_redirect;
    logic              ex_md_req;
    logic              md_done;

    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              stall_pc;
    logic              stall_if_id;
    logic              stall_id_ex;
    logic              stall_ex_mem;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              md_start;
    logic              md_err;

    modport master (
        output id_rs1, id_rs2, id_rs1_re, id_rs2_re,
        output ex_rd, mem_rd, wb_rd, ex_wen, mem_wen, wb_wen,
        output ex_is_load, ex_redirect, ex_md_req, md_done,
        input  fwd_a_sel, fwd_b_sel,
        input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
        input  flush_if_id, flush_id_ex, md_start, md_err
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_re, id_rs2_re,
        input  ex_rd, mem_rd, wb_rd, ex_wen, mem_wen, wb_wen,
        input  ex_is_load, ex_redirect, ex_md_req, md_done,
        output fwd_a_sel, fwd_b_sel,
        output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
        output flush_if_id, flush_id_ex, md_start, md_err
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Combinational forwarding-source picker for one ID operand; the youngest
// writer (EX, then MEM, then WB) wins, x0 and unread operands use the regfile.
module pipe_hazard_ctrl_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic              re_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_wen_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_wen_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_wen_i,
    output logic [1:0]        sel_o
);

    always_comb begin
        sel_o = FWD_SEL_RF;
        if (re_i && (rs_i != '0)) begin
            if (ex_wen_i && (ex_rd_i == rs_i)) begin
                sel_o = FWD_SEL_EX;
            end else if (mem_wen_i && (mem_rd_i == rs_i)) begin
                sel_o = FWD_SEL_MEM;
            end else if (wb_wen_i && (wb_rd_i == rs_i)) begin
                sel_o = FWD_SEL_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage miniRV pipeline, with
// mul/div sequencing FSM and watchdog. Optional perf counters: HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MD_MAX_CYC = 64
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst_n,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt,
    output logic [31:0]        perf_md_cnt,
`endif
    pipe_hazard_ctrl_if.slave  bus
);

    localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_MAX_CYC - 1);

    md_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic                mdErr_q, mdErr_d;
    logic                mdStart;
    logic                loadUse;
    pipe_ctrl_t          ctrl;

    pipe_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) uFwdA (
        .rs_i      (bus.id_rs1),
        .re_i      (bus.id_rs1_re),
        .ex_rd_i   (bus.ex_rd),
        .ex_wen_i  (bus.ex_wen),
        .mem_rd_i  (bus.mem_rd),
        .mem_wen_i (bus.mem_wen),
        .wb_rd_i   (bus.wb_rd),
        .wb_wen_i  (bus.wb_wen),
        .sel_o     (bus.fwd_a_sel)
    );

    pipe_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) uFwdB (
        .rs_i      (bus.id_rs2),
        .re_i      (bus.id_rs2_re),
        .ex_rd_i   (bus.ex_rd),
        .ex_wen_i  (bus.ex_wen),
        .mem_rd_i  (bus.mem_rd),
        .mem_wen_i (bus.mem_wen),
        .wb_rd_i   (bus.wb_rd),
        .wb_wen_i  (bus.wb_wen),
        .sel_o     (bus.fwd_b_sel)
    );

    // A load in EX cannot forward in time; the dependent ID op must wait a cycle.
    assign loadUse = bus.ex_is_load && bus.ex_wen && (bus.ex_rd != '0) &&
                     (((bus.id_rs1 == bus.ex_rd) && bus.id_rs1_re) ||
                      ((bus.id_rs2 == bus.ex_rd) && bus.id_rs2_re));

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q   <= MD_FSM_RUN;
            waitCnt_q <= '0;
            mdErr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            mdErr_q   <= mdErr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        mdErr_d   = 1'b0;
        mdStart   = 1'b0;
        ctrl      = PIPE_CTRL_IDLE;
        case (state_q)
            MD_FSM_RUN: begin
                if (bus.ex_redirect) begin
                    ctrl.flush_if_id = 1'b1;
                    ctrl.flush_id_ex = 1'b1;
                end else if (bus.ex_md_req) begin
                    mdStart   = 1'b1;
                    ctrl      = freezeAll();
                    state_d   = MD_FSM_WAIT;
                    waitCnt_d = '0;
                end else if (loadUse) begin
                    ctrl.stall_pc    = 1'b1;
                    ctrl.stall_if_id = 1'b1;
                    ctrl.flush_id_ex = 1'b1;
                end
            end
            // Redirect and load-use are ignored here: EX is frozen on the md op.
            MD_FSM_WAIT: begin
                if (bus.md_done) begin
                    state_d = MD_FSM_RUN;
                end else if (waitCnt_q == MD_LAST) begin
                    mdErr_d = 1'b1;
                    state_d = MD_FSM_RUN;
                end else begin
                    ctrl      = freezeAll();
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = MD_FSM_RUN;
            end
        endcase
    end

    assign bus.stall_pc     = ctrl.stall_pc;
    assign bus.stall_if_id  = ctrl.stall_if_id;
    assign bus.stall_id_ex  = ctrl.stall_id_ex;
    assign bus.stall_ex_mem = ctrl.stall_ex_mem;
    assign bus.flush_if_id  = ctrl.flush_if_id;
    assign bus.flush_id_ex  = ctrl.flush_id_ex;
    assign bus.md_start     = mdStart;
    assign bus.md_err       = mdErr_q;

`ifdef HAZARD_PERF_CNT_EN
    logic        redirectTaken;
    logic [31:0] perfStall_q, perfFlush_q, perfMd_q;

    assign redirectTaken = (state_q == MD_FSM_RUN) && bus.ex_redirect;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            perfStall_q <= '0;
            perfFlush_q <= '0;
            perfMd_q    <= '0;
        end else begin
            if (ctrl.stall_pc) begin
                perfStall_q <= perfStall_q + 32'd1;
            end
            if (redirectTaken) begin
                perfFlush_q <= perfFlush_q + 32'd1;
            end
            if (mdStart) begin
                perfMd_q <= perfMd_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perfStall_q;
    assign perf_flush_cnt = perfFlush_q;
    assign perf_md_cnt    = perfMd_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (default MD_MAX_CYC=64).
// Perf counter checks compile in only when HAZARD_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic       re1;
        logic [4:0] rs2;
        logic       re2;
        logic [4:0] exRd;
        logic       exWen;
        logic [4:0] memRd;
        logic       memWen;
        logic [4:0] wbRd;
        logic       wbWen;
        logic       isLoad;
        logic       redirect;
        logic       mdReq;
        logic       mdDone;
    } stim_t;

    localparam stim_t IDLE = '0;
    localparam logic [5:0] CTRL_NONE   = 6'b000000;
    localparam logic [5:0] CTRL_LDUSE  = 6'b110001;
    localparam logic [5:0] CTRL_FLUSH  = 6'b000011;
    localparam logic [5:0] CTRL_FREEZE = 6'b111100;

    logic  cpu_clk = 1'b0;
    logic  cpu_rst_n = 1'b0;
    stim_t stim;
    int    testCount = 0;
    int    failCount = 0;
    int    freezeCycles;
    int    errPulses;
    logic [5:0] ctrlVec;

    pipe_hazard_ctrl_if #(.REG_AW(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perfStall, perfFlush, perfMd;
`endif

    pipe_hazard_ctrl #(.REG_AW(5), .MD_MAX_CYC(64)) dut (
        .cpu_clk        (cpu_clk),
        .cpu_rst_n      (cpu_rst_n),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cnt (perfStall),
        .perf_flush_cnt (perfFlush),
        .perf_md_cnt    (perfMd),
`endif
        .bus            (bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    assign ctrlVec = {bus.stall_pc, bus.stall_if_id, bus.stall_id_ex,
                      bus.stall_ex_mem, bus.flush_if_id, bus.flush_id_ex};

    task automatic applyStimulus(input stim_t s);
        bus.id_rs1      = s.rs1;
        bus.id_rs1_re   = s.re1;
        bus.id_rs2      = s.rs2;
        bus.id_rs2_re   = s.re2;
        bus.ex_rd       = s.exRd;
        bus.ex_wen      = s.exWen;
        bus.mem_rd      = s.memRd;
        bus.mem_wen     = s.memWen;
        bus.wb_rd       = s.wbRd;
        bus.wb_wen      = s.wbWen;
        bus.ex_is_load  = s.isLoad;
        bus.ex_redirect = s.redirect;
        bus.ex_md_req   = s.mdReq;
        bus.md_done     = s.mdDone;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextEdge();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge cpu_clk);
    endtask

    initial begin
        // Reset with idle inputs
        stim = IDLE;
        applyStimulus(stim);
        cpu_rst_n = 1'b0;
        sample();
        checkOutput("rst_ctrl", 32'(ctrlVec), 32'(CTRL_NONE));
        checkOutput("rst_fwd", {28'd0, bus.fwd_a_sel, bus.fwd_b_sel}, 32'd0);
        checkOutput("rst_md", {30'd0, bus.md_start, bus.md_err}, 32'd0);
        sample();
        cpu_rst_n = 1'b1;

        // Forwarding priority
        nextEdge();
        stim = IDLE;
        stim.rs1 = 5'd5; stim.re1 = 1'b1;
        stim.exRd = 5'd5; stim.exWen = 1'b1;
        stim.memRd = 5'd5; stim.memWen = 1'b1;
        applyStimulus(stim);
        sample();
        checkOutput("fwd_ex_over_mem", 32'(bus.fwd_a_sel), 32'd1);
        checkOutput("fwd_no_stall", 32'(ctrlVec), 32'(CTRL_NONE));
        nextEdge();
        stim.exWen = 1'b0;
        applyStimulus(stim);
        sample();
        checkOutput("fwd_mem", 32'(bus.fwd_a_sel), 32'd2);
        nextEdge();
        stim.rs1 = 5'd0;
        applyStimulus(stim);
        sample();
        checkOutput("fwd_x0", 32'(bus.fwd_a_sel), 32'd0);
        nextEdge();
        stim = IDLE;
        stim.rs1 = 5'd9; stim.re1 = 1'b0;
        stim.rs2 = 5'd9; stim.re2 = 1'b1;
        stim.wbRd = 5'd9; stim.wbWen = 1'b1;
        stim.memRd = 5'd9; stim.memWen = 1'b0;
        applyStimulus(stim);
        sample();
        checkOutput("fwd_b_wb", 32'(bus.fwd_b_sel), 32'd3);
        checkOutput("fwd_a_unread", 32'(bus.fwd_a_sel), 32'd0);

        // Load-use bubble then MEM forwarding
        nextEdge();
        stim = IDLE;
        stim.rs2 = 5'd7; stim.re2 = 1'b1;
        stim.exRd = 5'd7; stim.exWen = 1'b1; stim.isLoad = 1'b1;
        applyStimulus(stim);
        sample();
        checkOutput("lduse_ctrl", 32'(ctrlVec), 32'(CTRL_LDUSE));
        checkOutput("lduse_fwd_b", 32'(bus.fwd_b_sel), 32'd1);
        nextEdge();
        stim = IDLE;
        stim.rs2 = 5'd7; stim.re2 = 1'b1;
        stim.exRd = 5'd3; stim.exWen = 1'b1;
        stim.memRd = 5'd7; stim.memWen = 1'b1;
        applyStimulus(stim);
        sample();
        checkOutput("lduse_after_ctrl", 32'(ctrlVec), 32'(CTRL_NONE));
        checkOutput("lduse_after_fwd_b", 32'(bus.fwd_b_sel), 32'd2);
        nextEdge();
        stim = IDLE;
        stim.rs2 = 5'd7; stim.re2 = 1'b0;
        stim.exRd = 5'd7; stim.exWen = 1'b1; stim.isLoad = 1'b1;
        applyStimulus(stim);
        sample();
        checkOutput("lduse_unread", 32'(ctrlVec), 32'(CTRL_NONE));
        nextEdge();
        stim.rs2 = 5'd0; stim.re2 = 1'b1; stim.exRd = 5'd0;
        applyStimulus(stim);
        sample();
        checkOutput("lduse_x0", 32'(ctrlVec), 32'(CTRL_NONE));

        // Redirect beats load-use
        nextEdge();
        stim = IDLE;
        stim.rs1 = 5'd4; stim.re1 = 1'b1;
        stim.exRd = 5'd4; stim.exWen = 1'b1; stim.isLoad = 1'b1;
        stim.redirect = 1'b1;
        applyStimulus(stim);
        sample();
        checkOutput("redir_over_lduse", 32'(ctrlVec), 32'(CTRL_FLUSH));

        // Redirect beats md request
        nextEdge();
        stim = IDLE;
        stim.redirect = 1'b1; stim.mdReq = 1'b1;
        applyStimulus(stim);
        sample();
        checkOutput("redir_over_md_ctrl", 32'(ctrlVec), 32'(CTRL_FLUSH));
        checkOutput("redir_over_md_start", 32'(bus.md_start), 32'd0);

        // Mul/div op completing at cycle 5
        nextEdge();
        stim = IDLE;
        stim.mdReq = 1'b1;
        applyStimulus(stim);
        sample();
        checkOutput("md_c0_start", 32'(bus.md_start), 32'd1);
        checkOutput("md_c0_ctrl", 32'(ctrlVec), 32'(CTRL_FREEZE));
        for (int c = 1; c <= 4; c++) begin
            nextEdge();
            if (c == 2) begin
                stim.redirect = 1'b1;
                stim.rs1 = 5'd6; stim.re1 = 1'b1;
                stim.exRd = 5'd6; stim.exWen = 1'b1; stim.isLoad = 1'b1;
                applyStimulus(stim);
            end
            sample();
            checkOutput($sformatf("md_c%0d_ctrl", c), 32'(ctrlVec), 32'(CTRL_FREEZE));
            checkOutput($sformatf("md_c%0d_start", c), 32'(bus.md_start), 32'd0);
        end
        nextEdge();
        stim.mdDone = 1'b1;
        applyStimulus(stim);
        sample();
        checkOutput("md_c5_release", 32'(ctrlVec), 32'(CTRL_NONE));
        nextEdge();
        stim = IDLE;
        stim.redirect = 1'b1;
        applyStimulus(stim);
        sample();
        checkOutput("md_c6_run", 32'(ctrlVec), 32'(CTRL_FLUSH));
        checkOutput("md_c6_err", 32'(bus.md_err), 32'd0);
        nextEdge();
        stim = IDLE;
        stim.mdDone = 1'b1;
        applyStimulus(stim);
        sample();
        checkOutput("done_in_run", 32'(ctrlVec), 32'(CTRL_NONE));

        // Watchdog: md_done never arrives
        nextEdge();
        stim = IDLE;
        stim.mdReq = 1'b1;
        applyStimulus(stim);
        sample();
        checkOutput("wd_start", 32'(bus.md_start), 32'd1);
        freezeCycles = 0;
        errPulses = 0;
        for (int c = 1; c <= 63; c++) begin
            nextEdge();
            sample();
            if (ctrlVec == CTRL_FREEZE) freezeCycles++;
            if (bus.md_err) errPulses++;
        end
        checkOutput("wd_freeze_cycles", 32'(freezeCycles), 32'd63);
        checkOutput("wd_no_early_err", 32'(errPulses), 32'd0);
        nextEdge();
        stim.mdReq = 1'b0;
        applyStimulus(stim);
        sample();
        checkOutput("wd_abort_release", 32'(ctrlVec), 32'(CTRL_NONE));
        checkOutput("wd_abort_err_lag", 32'(bus.md_err), 32'd0);
        nextEdge();
        sample();
        checkOutput("wd_err_pulse", 32'(bus.md_err), 32'd1);
        checkOutput("wd_err_ctrl", 32'(ctrlVec), 32'(CTRL_NONE));
        nextEdge();
        sample();
        checkOutput("wd_err_single", 32'(bus.md_err), 32'd0);

        // Reset during MD_WAIT aborts silently
        nextEdge();
        stim = IDLE;
        stim.mdReq = 1'b1;
        applyStimulus(stim);
        nextEdge();
        nextEdge();
        sample();
        checkOutput("rstwait_pre", 32'(ctrlVec), 32'(CTRL_FREEZE));
        nextEdge();
        stim.mdReq = 1'b0;
        applyStimulus(stim);
        cpu_rst_n = 1'b0;
        #1;
        checkOutput("rstwait_drop", 32'(ctrlVec), 32'(CTRL_NONE));
        errPulses = 0;
        for (int c = 0; c < 3; c++) begin
            sample();
            if (bus.md_err) errPulses++;
            if (c == 1) cpu_rst_n = 1'b1;
        end
        nextEdge();
        stim.redirect = 1'b1;
        applyStimulus(stim);
        sample();
        if (bus.md_err) errPulses++;
        checkOutput("rstwait_no_err", 32'(errPulses), 32'd0);
        checkOutput("rstwait_run", 32'(ctrlVec), 32'(CTRL_FLUSH));

`ifdef HAZARD_PERF_CNT_EN
        // Perf counters: 3 load-use, 2 redirects, 1 md op (2 frozen cycles)
        nextEdge();
        stim = IDLE;
        applyStimulus(stim);
        cpu_rst_n = 1'b0;
        sample();
        cpu_rst_n = 1'b1;
        checkOutput("perf_rst", perfStall | perfFlush | perfMd, 32'd0);
        stim.rs1 = 5'd8; stim.re1 = 1'b1;
        stim.exRd = 5'd8; stim.exWen = 1'b1; stim.isLoad = 1'b1;
        for (int c = 0; c < 3; c++) begin
            nextEdge();
            applyStimulus(stim);
        end
        stim = IDLE;
        stim.redirect = 1'b1;
        for (int c = 0; c < 2; c++) begin
            nextEdge();
            applyStimulus(stim);
        end
        nextEdge();
        stim = IDLE;
        stim.mdReq = 1'b1;
        applyStimulus(stim);
        nextEdge();
        nextEdge();
        stim.mdDone = 1'b1;
        applyStimulus(stim);
        nextEdge();
        stim = IDLE;
        applyStimulus(stim);
        sample();
        checkOutput("perf_stall", perfStall, 32'd5);
        checkOutput("perf_flush", perfFlush, 32'd2);
        checkOutput("perf_md", perfMd, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
